// File: rtl/wide_add_pkg.sv
// Shared constants and FSM state type for the nibble-serial wide adder controller.
package wide_add_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } wa_state_e;

endpackage

// File: rtl/wide_add_seq.sv
// Drives an external 4-bit ripple adder one nibble per cycle (LSB first) to form a
// WIDTH-bit sum, with valid/ready handshakes on both the operand and result sides.
module wide_add_seq
  import wide_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_co,
  output logic [NIB_W-1:0] add_a,
  output logic [NIB_W-1:0] add_b,
  output logic             add_cin,
  input  logic [NIB_W-1:0] add_sum,
  input  logic             add_co
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIB - 1);

  wa_state_e        state;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             c_q;
  logic             co_q;
  logic             take;

  // In DONE the retiring result frees the operand registers, so a new pair can land on the same edge.
  assign in_ready  = rst_n && ((state == IDLE) || ((state == DONE) && out_ready));
  assign take      = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign out_sum   = out_valid ? sum_q : '0;
  assign out_co    = out_valid & co_q;

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a   = a_q[idx*NIB_W +: NIB_W];
      add_b   = b_q[idx*NIB_W +: NIB_W];
      add_cin = c_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
      c_q   <= 1'b0;
      co_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) state <= RUN;
        end
        RUN: begin
          sum_q[idx*NIB_W +: NIB_W] <= add_sum;
          c_q <= add_co;
          idx <= idx + 1'b1;
          if (idx == LAST) begin
            co_q  <= add_co;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= in_valid ? RUN : IDLE;
        end
        default: state <= IDLE;
      endcase
      if (take) begin
        a_q <= in_a;
        b_q <= in_b;
        c_q <= in_cin;
        idx <= '0;
      end
    end
  end

endmodule

// File: tb/tb_wide_add_seq.sv
// Scoreboard bench for wide_add_seq: 16-bit instance with random and directed traffic,
// plus a 4-bit instance for the single-pass case. The 4-bit adders live in the bench.
module tb_wide_add_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_cin, out_valid, out_ready, out_co;
  logic [15:0] in_a, in_b, out_sum;
  logic [3:0]  add_a, add_b, add_sum;
  logic        add_cin, add_co;

  logic        in_valid4, in_ready4, in_cin4, out_valid4, out_ready4, out_co4;
  logic [3:0]  in_a4, in_b4, out_sum4;
  logic [3:0]  add_a4, add_b4, add_sum4;
  logic        add_cin4, add_co4;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit rnd_bp = 0;
  bit prev_vld = 0;

  logic [16:0] sb[$];
  int          acc_q[$];
  int          ret_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign {add_co, add_sum}   = 5'(add_a) + 5'(add_b) + 5'(add_cin);
  assign {add_co4, add_sum4} = 5'(add_a4) + 5'(add_b4) + 5'(add_cin4);

  wide_add_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_co(out_co),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_co(add_co)
  );

  wide_add_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .in_a(in_a4), .in_b(in_b4), .in_cin(in_cin4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .out_sum(out_sum4), .out_co(out_co4),
    .add_a(add_a4), .add_b(add_b4), .add_cin(add_cin4),
    .add_sum(add_sum4), .add_co(add_co4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [16:0] ref_add(input logic [15:0] a, input logic [15:0] b, input logic c);
    return 17'(a) + 17'(b) + 17'(c);
  endfunction

  // Monitor: latency on each out_valid rise, result compare on each retire.
  always @(negedge clk) begin
    logic [16:0] e;
    if (rst_n) begin
      if (out_valid && !prev_vld) begin
        if (acc_q.size() == 0) chk("latency_no_accept", 32'd1, 32'd0);
        else chk("latency", 32'(cyc - acc_q.pop_front()), 32'd4);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_result", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          chk("result", 32'({out_co, out_sum}), 32'(e));
          ret_q.push_back(cyc);
        end
      end
      prev_vld = out_valid;
    end else begin
      prev_vld = 1'b0;
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic c, input bit keep);
    bit got = 0;
    in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin got = 1; break; end
      @(posedge clk); #1;
      if (rnd_bp) out_ready = 1'($urandom_range(0, 1));
    end
    if (!got) begin
      chk("accept_timeout", 32'd1, 32'd0);
      in_valid = 1'b0;
      return;
    end
    sb.push_back(ref_add(a, b, c));
    @(posedge clk); #1;
    acc_q.push_back(cyc);
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 200 && sb.size() != 0; t++) @(negedge clk);
    chk("drain", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [15:0] s_hold;
    logic        c_hold;
    logic [15:0] ra, rb;
    bit          seen;

    rst_n = 1'b0;
    in_valid = 0; in_a = '0; in_b = '0; in_cin = 0; out_ready = 1'b1;
    in_valid4 = 0; in_a4 = '0; in_b4 = '0; in_cin4 = 0; out_ready4 = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    chk("rst_add_a", 32'({add_a, add_b, add_cin}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Overflow across every nibble
    send(16'hFFFF, 16'h0001, 1'b0, 0);
    wait_drain();

    // Nibble sequence on the adder port
    send(16'h1234, 16'h4321, 1'b1, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("add_a_seq", 32'(add_a), 32'((16'h1234 >> (4 * k)) & 16'hF));
      chk("add_b_seq", 32'(add_b), 32'((16'h4321 >> (4 * k)) & 16'hF));
    end
    wait_drain();

    // Back-to-back with in_valid held high
    ret_q.delete();
    send(16'h00FF, 16'h0001, 1'b0, 1);
    send(16'h8000, 16'h8000, 1'b0, 1);
    send(16'h0F0F, 16'hF0F0, 1'b0, 0);
    wait_drain();
    chk("b2b_count", 32'(ret_q.size()), 32'd3);
    if (ret_q.size() == 3) begin
      chk("b2b_gap1", 32'(ret_q[1] - ret_q[0]), 32'd5);
      chk("b2b_gap2", 32'(ret_q[2] - ret_q[1]), 32'd5);
    end

    // Backpressure in DONE
    out_ready = 1'b0;
    send(16'hABCD, 16'h1357, 1'b0, 0);
    seen = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (out_valid) begin seen = 1; break; end
    end
    chk("bp_valid_seen", 32'(seen), 32'd1);
    s_hold = out_sum; c_hold = out_co;
    chk("bp_value", 32'({c_hold, s_hold}), 32'(ref_add(16'hABCD, 16'h1357, 1'b0)));
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      in_valid = 1'($urandom_range(0, 1));
      in_a = 16'($urandom); in_b = 16'($urandom);
      @(negedge clk);
      chk("bp_stable", 32'({out_valid, out_co, out_sum}), 32'({1'b1, c_hold, s_hold}));
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    wait_drain();

    // Reset during RUN at idx 2
    send(16'h1111, 16'h2222, 1'b0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", 32'({out_valid, out_co, out_sum}), 32'd0);
    chk("mid_rst_add", 32'({add_a, add_b, add_cin}), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    sb.delete(); acc_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk("mid_rst_no_result", 32'(seen), 32'd0);
    @(posedge clk); #1;
    send(16'h0001, 16'h0001, 1'b0, 0);
    wait_drain();

    // Randomized traffic with random backpressure
    rnd_bp = 1;
    for (int n = 0; n < 25; n++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      send(ra, rb, 1'($urandom_range(0, 1)), 0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        out_ready = 1'($urandom_range(0, 1));
      end
    end
    rnd_bp = 0;
    out_ready = 1'b1;
    wait_drain();

    // Single-nibble instance
    @(posedge clk); #1;
    in_a4 = 4'hF; in_b4 = 4'hF; in_cin4 = 1'b1; in_valid4 = 1'b1;
    @(negedge clk);
    chk("w4_in_ready", 32'(in_ready4), 32'd1);
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    @(negedge clk);
    chk("w4_run_valid", 32'(out_valid4), 32'd0);
    chk("w4_run_add", 32'({add_a4, add_b4, add_cin4}), 32'({4'hF, 4'hF, 1'b1}));
    @(negedge clk);
    chk("w4_result", 32'({out_valid4, out_co4, out_sum4}), 32'({1'b1, 1'b1, 4'hF}));
    @(posedge clk); #1;
    @(negedge clk);
    chk("w4_back_idle", 32'({out_valid4, in_ready4}), 32'({1'b0, 1'b1}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wide_add_seq.md
# wide_add_seq

Sequential controller that performs a WIDTH-bit addition by driving the existing 4-bit ripple adder one nibble per cycle, LSB nibble first, chaining the carry between passes. It sits directly upstream of the 4-bit adder stage: it accepts operand pairs on a valid/ready input, feeds nibble slices into the adder's `a`/`b`/`cin` signals, and captures `sum`/`co` back. It returns the full-width result on a valid/ready output.

## Interface
- `WIDTH`, 16: operand width; must be a multiple of 4 and at least 4.
- `NIB`, WIDTH/4: derived number of nibble passes; not overridable.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand pair present.
- `in_ready`  out  1  block can accept an operand pair.
- `in_a`, `in_b`  in  WIDTH  operands.
- `in_cin`  in  1  carry-in to bit 0.
- `out_valid`  out  1  result held on `out_sum`/`out_co`.
- `out_ready`  in  1  consumer takes the result.
- `out_sum`  out  WIDTH  result, modulo 2^WIDTH.
- `out_co`  out  1  carry out of bit WIDTH-1.
- `add_a`, `add_b`  out  4  nibble slice driven to the adder.
- `add_cin`  out  1  carry driven to the adder.
- `add_sum`  in  4  adder sum (combinational response).
- `add_co`  in  1  adder carry-out.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`, latch `in_a`, `in_b`, `in_cin` into `a_q`, `b_q`, `c_q`; `idx`<=0; go to RUN.
- RUN:
  - Drive `add_a`=`a_q[4*idx+:4]`, `add_b`=`b_q[4*idx+:4]`, `add_cin`=`c_q`.
  - Each edge: `sum_q[4*idx+:4]`<=`add_sum`; `c_q`<=`add_co`; `idx`<=`idx`+1.
  - At `idx`==NIB-1: also `co_q`<=`add_co`; go to DONE.
- DONE:
  - `out_valid`=1; `out_sum`=`sum_q`; `out_co`=`co_q`; all held stable until `out_ready`.
  - On `out_ready` with `in_valid` low: go to IDLE.
- Back-to-back: in DONE, `in_ready`=`out_ready`. If `out_ready` and `in_valid` are both high, the result retires and new operands latch in the same edge; go straight to RUN with `idx`=0.
- Outside RUN, `add_a`/`add_b`/`add_cin` are driven 0.
- The `in_*` buses are ignored after capture; changing them during RUN has no effect.
- `idx` width is clog2(NIB), minimum 1. For NIB=1, RUN lasts exactly one cycle.
- Arithmetic is unsigned; overflow is reported only through `out_co`.

## Timing
- Reset (async assert, any state): state=IDLE, `idx`=0, `a_q`/`b_q`/`sum_q`=0, `c_q`/`co_q`=0, `out_valid`=0, `out_sum`=0, `out_co`=0, `add_*`=0.
- `in_ready`=0 while `rst_n` is low.
- Deassertion is used as-is; the synchronizer is external.
- Latency: with the accept at edge E, `out_valid` rises after edge E+NIB. That is 4 cycles for WIDTH=16.
- Throughput:
  - With `out_ready` tied high, one result per NIB+1 cycles.
  - With an IDLE gap between operations, one result per NIB+2 cycles.
- Reset mid-RUN or mid-DONE: the operation is discarded and no result is emitted.
- The adder path is purely combinational in one cycle: `add_*` outputs are registered-state-derived, and `add_sum`/`add_co` are sampled at the next edge.

## Structure
- Package `wide_add_pkg`: `NIB_W`=4 constant and the state enum `wa_state_e` {IDLE, RUN, DONE}.
- No sub-module. The 4-bit adder remains a separate instance, wired through its interface at the parent level.

## Test plan
- WIDTH=16, a=0xFFFF, b=0x0001, cin=0 -> `out_sum`=0x0000, `out_co`=1; `out_valid` 4 cycles after the accept edge.
- a=0x1234, b=0x4321, cin=1 -> `out_sum`=0x5556, `out_co`=0. Check `add_a` sequence 4, 3, 2, 1 across RUN cycles.
- Back-to-back: `out_ready`=1 with `in_valid` held high and 3 operand pairs (0x00FF+0x0001, 0x8000+0x8000, 0x0F0F+0xF0F0) -> results 0x0100/co 0, 0x0000/co 1, 0xFFFF/co 0, each 5 cycles apart.
- Backpressure: hold `out_ready`=0 for 6 cycles in DONE -> `out_sum`/`out_co` stable, `in_ready`=0, `in_valid` pulses ignored.
- Reset asserted in RUN at `idx`=2 -> all outputs 0 immediately, no `out_valid`. A new op 0x0001+0x0001 afterwards -> 0x0002.
- WIDTH=4: a=0xF, b=0xF, cin=1 -> `out_sum`=0xF, `out_co`=1, `out_valid` 1 cycle after accept.
